// File: rtl/lcd1602_bus_arbiter.sv
// Two-requester arbiter that owns an HD44780-style LCD1602 bus and
// drives the setup/pulse/hold/execute timing for each accepted byte.
module lcd1602_bus_arbiter #(
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_PULSE     = 25,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 80000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] valid,
    input  logic [1:0] rs_in,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic       ack,
    output logic       busy,
    output logic       rs,
    output logic       rw,
    output logic       enable,
    output logic [7:0] data
);

    // A zero-length phase still occupies one cycle.
    localparam int unsigned S_LEN = (T_SETUP     == 0) ? 1 : T_SETUP;
    localparam int unsigned P_LEN = (T_PULSE     == 0) ? 1 : T_PULSE;
    localparam int unsigned H_LEN = (T_HOLD      == 0) ? 1 : T_HOLD;
    localparam int unsigned E_LEN = (T_EXEC      == 0) ? 1 : T_EXEC;
    localparam int unsigned L_LEN = (T_EXEC_LONG == 0) ? 1 : T_EXEC_LONG;

    localparam int unsigned M_A = (S_LEN > P_LEN) ? S_LEN : P_LEN;
    localparam int unsigned M_B = (H_LEN > E_LEN) ? H_LEN : E_LEN;
    localparam int unsigned M_C = (M_A > M_B) ? M_A : M_B;
    localparam int unsigned MAX_LEN = (M_C > L_LEN) ? M_C : L_LEN;
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t S_LAST = cnt_t'(S_LEN - 1);
    localparam cnt_t P_LAST = cnt_t'(P_LEN - 1);
    localparam cnt_t H_LAST = cnt_t'(H_LEN - 1);
    localparam cnt_t E_LAST = cnt_t'(E_LEN - 1);
    localparam cnt_t L_LAST = cnt_t'(L_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [1:0] gnt_q, gnt_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       ack_q, ack_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       long_cmd;

    // Clear display and return home need the long execution wait.
    assign long_cmd = !rs_q && (data_q == 8'h01 || data_q == 8'h02);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= 2'b00;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            ack_q   <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        ack_d   = 1'b0;
        rs_d    = rs_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    unique case (1'b1)
                        req[0] && (!req[1] || last_q): owner_d = 1'b0;
                        default:                       owner_d = 1'b1;
                    endcase
                    gnt_d   = owner_d ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    gnt_d   = 2'b00;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (valid[owner_q]) begin
                    rs_d    = rs_in[owner_q];
                    data_d  = owner_q ? data1 : data0;
                    ack_d   = 1'b1;
                    cnt_d   = S_LAST;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = P_LAST;
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = H_LAST;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = long_cmd ? L_LAST : E_LAST;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = GRANT;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Decoded from the async-reset state so enable drops with reset.
    assign enable = (state_q == PULSE);
    assign busy   = (state_q == SETUP) || (state_q == PULSE) ||
                    (state_q == HOLD)  || (state_q == EXEC);
    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign rs     = rs_q;
    assign rw     = 1'b0;
    assign data   = data_q;

endmodule
